// File: rtl/sum_datapath_responder.sv
// sum_datapath_responder
//   Far-end responder for the adder sequencer. Holds the operand RAM, the
//   running-sum accumulator and a bank of per-group sums. It also flags
//   protocol violations and accumulator overflow.
// Ports
//   clk, reset       clock (posedge) and async active-low reset
//   address, rden    sequencer read index / read enable (1-cycle latency)
//   wren             bank sum_out into res[address/GROUP]
//   load             accumulate the fetched word
//   clear            active-low accumulator clear
//   transf           copy accumulator to sum_out
//   ready            end-of-pass strobe, echoed on done one cycle later
//   init_we/addr/data  RAM preload port
//   rd_data, rd_valid  registered read data and its valid flag
//   sum_out, res0..3   transferred sum and banked group sums
//   done, ovf, err_proto  pass-done pulse, sticky overflow, sticky protocol error
module sum_datapath_responder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 11,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned GROUP  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(DEPTH)-1:0]  address,
  input  logic                      rden,
  input  logic                      wren,
  input  logic                      load,
  input  logic                      clear,
  input  logic                      transf,
  input  logic                      ready,
  input  logic                      init_we,
  input  logic [$clog2(DEPTH)-1:0]  init_addr,
  input  logic [DATA_W-1:0]         init_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic [ACC_W-1:0]          sum_out,
  output logic [ACC_W-1:0]          res0,
  output logic [ACC_W-1:0]          res1,
  output logic [ACC_W-1:0]          res2,
  output logic [ACC_W-1:0]          res3,
  output logic                      done,
  output logic                      ovf,
  output logic                      err_proto
);

  localparam int unsigned NRES = DEPTH / GROUP;
  localparam int unsigned GW   = $clog2(GROUP);
  localparam int unsigned RW   = $clog2(NRES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  sum_out_q, sum_out_d;
  logic [ACC_W-1:0]  res_q [NRES];
  logic [ACC_W-1:0]  res_d [NRES];
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic [ACC_W:0]    acc_sum;
  logic [RW-1:0]     bank;
  logic              fetched;

  // Operand RAM: preload port only, contents survive reset
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_addr] <= init_data;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    rd_data_d  = rd_data_q;
    acc_d      = acc_q;
    sum_out_d  = sum_out_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    done_d     = ready;
    fetched    = (state_q != S_IDLE);
    acc_sum    = (ACC_W+1)'(acc_q) + (ACC_W+1)'(rd_data_q);
    bank       = RW'(address >> GW);

    case (state_q)
      S_IDLE:          if (rden) state_d = S_FETCH;
      S_FETCH, S_HOLD: state_d = rden ? S_HOLD : S_IDLE;
      default:         state_d = S_IDLE;
    endcase
    rd_valid_d = (state_d != S_IDLE);

    // Reads see the RAM before any same-edge preload write
    if (rden) begin
      rd_data_d = mem_q[address];
    end

    if (!clear) begin
      acc_d = '0;
    end else if (load && fetched) begin
      acc_d = acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) ovf_d = 1'b1;
    end

    // Transfer takes the accumulator value before any same-edge load
    if (transf) begin
      sum_out_d = acc_q;
    end

    if (wren) begin
      res_d[bank] = sum_out_q;
    end

    if ((load && !fetched) || (wren && (load || rden)) || (transf && load)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      acc_q      <= '0;
      sum_out_q  <= '0;
      for (int i = 0; i < int'(NRES); i++) res_q[i] <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      acc_q      <= acc_d;
      sum_out_q  <= sum_out_d;
      res_q      <= res_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign sum_out   = sum_out_q;
  assign res0      = res_q[0];
  assign res1      = res_q[1];
  assign res2      = res_q[2];
  assign res3      = res_q[3];
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign err_proto = err_q;

endmodule

// File: tb/tb_sum_datapath_responder.sv
// Scoreboard bench for sum_datapath_responder: directed scenarios plus random
// traffic, checked against a transaction-level model of the responder.
module tb_sum_datapath_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  address, init_addr;
  logic        rden, wren, load, clear, transf, ready, init_we;
  logic [7:0]  init_data;
  logic [7:0]  rd_data;
  logic        rd_valid, done, ovf, err_proto;
  logic [10:0] sum_out, res0, res1, res2, res3;

  always #5 clk = ~clk;

  sum_datapath_responder dut (
    .clk(clk), .reset(reset), .address(address), .rden(rden), .wren(wren),
    .load(load), .clear(clear), .transf(transf), .ready(ready),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .sum_out(sum_out),
    .res0(res0), .res1(res1), .res2(res2), .res3(res3),
    .done(done), .ovf(ovf), .err_proto(err_proto)
  );

  typedef struct packed {
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [10:0] sum_out, r0, r1, r2, r3;
    logic        done, ovf, err;
  } out_t;

  typedef struct {
    bit       rst_n, rden, wren, load, clear, transf, ready, init_we;
    bit [4:0] address, init_addr;
    bit [7:0] init_data;
  } stim_t;

  out_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state (plain integers, wrap handled arithmetically)
  int m_mem[32];
  int m_acc, m_sum, m_rd;
  int m_res[4];
  bit m_valid, m_done, m_ovf, m_err;

  function automatic out_t dut_out();
    return '{rd_data, rd_valid, sum_out, res0, res1, res2, res3, done, ovf, err_proto};
  endfunction

  function automatic out_t model_out();
    return '{8'(m_rd), m_valid, 11'(m_sum), 11'(m_res[0]), 11'(m_res[1]),
             11'(m_res[2]), 11'(m_res[3]), m_done, m_ovf, m_err};
  endfunction

  function automatic void check_out(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got rd=%h v=%b sum=%0d res=%0d/%0d/%0d/%0d done=%b ovf=%b err=%b | want rd=%h v=%b sum=%0d res=%0d/%0d/%0d/%0d done=%b ovf=%b err=%b",
               name, act.rd_data, act.rd_valid, act.sum_out, act.r0, act.r1, act.r2, act.r3,
               act.done, act.ovf, act.err, exp.rd_data, exp.rd_valid, exp.sum_out,
               exp.r0, exp.r1, exp.r2, exp.r3, exp.done, exp.ovf, exp.err);
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{rst_n: 1'b1, clear: 1'b1, default: '0};
    return s;
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_sum = 0; m_rd = 0;
    for (int i = 0; i < 4; i++) m_res[i] = 0;
    m_valid = 0; m_done = 0; m_ovf = 0; m_err = 0;
  endfunction

  // One clock: apply inputs mid-cycle, advance model, queue expected outputs
  task automatic cyc(input stim_t s);
    int t;
    @(negedge clk);
    #1;
    reset = s.rst_n; address = s.address; rden = s.rden; wren = s.wren;
    load = s.load; clear = s.clear; transf = s.transf; ready = s.ready;
    init_we = s.init_we; init_addr = s.init_addr; init_data = s.init_data;
    if (!s.rst_n) begin
      model_reset();
      #1 check_out("async_reset", dut_out(), '0);
    end else begin
      if (s.load && !m_valid) m_err = 1;
      if (s.wren && (s.load || s.rden)) m_err = 1;
      if (s.transf && s.load) m_err = 1;
      if (s.wren) m_res[s.address / 8] = m_sum;
      if (s.transf) m_sum = m_acc;
      if (!s.clear) m_acc = 0;
      else if (s.load && m_valid) begin
        t = m_acc + m_rd;
        if (t > 2047) m_ovf = 1;
        m_acc = t % 2048;
      end
      if (s.rden) m_rd = m_mem[s.address];
      m_valid = s.rden;
      m_done  = s.ready;
    end
    if (s.init_we) m_mem[s.init_addr] = s.init_data;
    @(posedge clk);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic do_reset();
    stim_t s = nop();
    s.rst_n = 0;
    cyc(s);
    cyc(nop());
  endtask

  task automatic preload(input int a, input int d);
    stim_t s = nop();
    s.init_we = 1; s.init_addr = 5'(a); s.init_data = 8'(d);
    cyc(s);
  endtask

  task automatic read_load(input int a);
    stim_t s = nop();
    s.rden = 1; s.address = 5'(a);
    cyc(s);
    s = nop(); s.load = 1;
    cyc(s);
  endtask

  // Sum one group of words and bank it; clr=0 keeps the previous accumulator
  task automatic run_group(input int g, input bit clr);
    stim_t s;
    if (clr) begin s = nop(); s.clear = 0; cyc(s); end
    for (int i = 0; i < 8; i++) read_load(g * 8 + i);
    s = nop(); s.transf = 1; cyc(s);
    s = nop(); s.wren = 1; s.address = 5'(g * 8); cyc(s);
  endtask

  // Monitor: compare every presented output sample against the scoreboard
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out("scoreboard", dut_out(), e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stim_t s;
    reset = 0; address = 0; rden = 0; wren = 0; load = 0; clear = 1;
    transf = 0; ready = 0; init_we = 0; init_addr = 0; init_data = 0;
    model_reset();
    do_reset();
    check_out("reset_state", dut_out(), '0);

    // T1: mem[i]=i, four groups, one ready pulse
    for (int i = 0; i < 32; i++) preload(i, i);
    for (int g = 0; g < 4; g++) run_group(g, 1);
    s = nop(); s.ready = 1; cyc(s);
    check_int("t1_done", int'(done), 1);
    cyc(nop());
    check_int("t1_done_end", int'(done), 0);
    check_int("t1_res0", int'(res0), 28);
    check_int("t1_res1", int'(res1), 92);
    check_int("t1_res2", int'(res2), 156);
    check_int("t1_res3", int'(res3), 220);
    check_int("t1_flags", int'({ovf, err_proto}), 0);

    // T2: full-scale words, then overflow by skipping the clear
    for (int i = 0; i < 32; i++) preload(i, 8'hFF);
    run_group(0, 1);
    check_int("t2_res0", int'(res0), 2040);
    check_int("t2_no_ovf", int'(ovf), 0);
    run_group(1, 0);
    check_int("t2_ovf", int'(ovf), 1);
    check_int("t2_res1_wrap", int'(res1), 2032);

    // T3: read latency and hold
    do_reset();
    preload(5, 8'h3C);
    s = nop(); s.rden = 1; s.address = 5; cyc(s);
    check_int("t3_valid", int'(rd_valid), 1);
    check_int("t3_data", int'(rd_data), 8'h3C);
    cyc(nop());
    check_int("t3_idle_valid", int'(rd_valid), 0);
    check_int("t3_hold_data", int'(rd_data), 8'h3C);

    // T4: load without a fetch, then wren together with load
    do_reset();
    s = nop(); s.load = 1; cyc(s);
    check_int("t4_err", int'(err_proto), 1);
    s = nop(); s.transf = 1; cyc(s);
    check_int("t4_acc_zero", int'(sum_out), 0);
    read_load(5);
    s = nop(); s.transf = 1; cyc(s);
    s = nop(); s.wren = 1; s.load = 1; s.address = 16; cyc(s);
    check_int("t4_res2", int'(res2), 8'h3C);

    // T5: preload and read collide on one address
    do_reset();
    preload(3, 8'h11);
    s = nop(); s.init_we = 1; s.init_addr = 3; s.init_data = 8'h22;
    s.rden = 1; s.address = 3; cyc(s);
    check_int("t5_old", int'(rd_data), 8'h11);
    s = nop(); s.rden = 1; s.address = 3; cyc(s);
    check_int("t5_new", int'(rd_data), 8'h22);

    // T6: reset mid-group, RAM survives
    for (int i = 0; i < 10; i++) preload(i, i);
    s = nop(); s.clear = 0; cyc(s);
    for (int i = 0; i < 10; i++) read_load(i);
    s = nop(); s.transf = 1; cyc(s);
    check_int("t6_acc45", int'(sum_out), 45);
    do_reset();
    s = nop(); s.rden = 1; s.address = 7; cyc(s);
    check_int("t6_ram_kept", int'(rd_data), 7);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      s = nop();
      s.rst_n     = ($urandom_range(99) >= 2);
      s.rden      = ($urandom_range(99) < 50);
      s.load      = ($urandom_range(99) < 35);
      s.wren      = ($urandom_range(99) < 10);
      s.transf    = ($urandom_range(99) < 15);
      s.ready     = ($urandom_range(99) < 10);
      s.clear     = ($urandom_range(99) >= 5);
      s.init_we   = ($urandom_range(99) < 20);
      s.address   = 5'($urandom_range(31));
      s.init_addr = 5'($urandom_range(31));
      s.init_data = 8'($urandom_range(255));
      cyc(s);
    end

    @(negedge clk);
    #2;
    check_int("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
